// File: rtl/hazard_pkg.sv
// Shared types for the hazard / forwarding controller.
//   fwd_sel_t  : EX operand mux select (RF, EX/MEM, MEM/WB, PC/imm)
//   hz_state_t : load-use stall FSM states
//   slot_t     : one in-flight instruction tracked by the scoreboard
package hazard_pkg;

  // Slot rd storage is fixed-width; narrower register addresses are zero-extended.
  localparam int SLOT_RD_W = 8;
  // Remaining-stall counter width; covers LOAD_STALL up to 3.
  localparam int HOLD_W    = 2;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_ALT   = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 wr_en;
    logic                 is_load;
  } slot_t;

  // Slot produces a value for register rs.
  function automatic logic slot_hit(slot_t s, logic [SLOT_RD_W-1:0] rs);
    return s.valid & s.wr_en & (s.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forwarding select (combinational).
//   rs_i/used_i/alt_i      : operand source register, read flag, PC/imm flag
//   ex_slot_i/mem_slot_i   : scoreboard slots of the two forwardable producers
//   sel_o                  : mux select for this operand
//   ex_load_hit_o          : operand depends on a load still in EX (load-use)
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  used_i,
  input  logic                  alt_i,
  input  slot_t                 ex_slot_i,
  input  slot_t                 mem_slot_i,
  output fwd_sel_t              sel_o,
  output logic                  ex_load_hit_o
);

  logic                 reads;
  logic                 ex_hit;
  logic                 mem_hit;
  logic [SLOT_RD_W-1:0] rs_ext;

  assign rs_ext = SLOT_RD_W'(rs_i);
  // r0 is hardwired zero, so it never depends on a producer.
  assign reads  = used_i & ~alt_i & (rs_i != '0);
  assign ex_hit  = reads & slot_hit(ex_slot_i, rs_ext);
  assign mem_hit = reads & slot_hit(mem_slot_i, rs_ext);
  assign ex_load_hit_o = ex_hit & ex_slot_i.is_load;

  // EX holds the newest producer, so it wins over MEM.
  always_comb begin
    sel_o = FWD_RF;
    if (alt_i)        sel_o = FWD_ALT;
    else if (ex_hit)  sel_o = FWD_EXMEM;
    else if (mem_hit) sel_o = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
//   clk, rst_n                 : clock, async active-low reset
//   id_*                       : decoded info of the instruction in ID
//   flush                      : taken branch/jump, kills ID and EX
//   stall_if_id, bubble_ex     : hold PC/IF-ID, insert NOP into ID/EX
//   fwd_a_sel, fwd_b_sel       : registered EX operand mux selects
//   stall_cycles               : saturating count of stalled cycles
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_alt_a,
  input  logic                  id_alt_b,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LOAD_STALL - 1);

  slot_t             ex_q, mem_q, wb_q, ex_d;
  hz_state_t         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q;
  fwd_sel_t          fwd_a_q, fwd_b_q;
  fwd_sel_t          sel_a, sel_b;
  logic              a_ld_hit, b_ld_hit;
  logic              hazard, stall, issue;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_i          (id_rs1),
    .used_i        (id_rs1_used),
    .alt_i         (id_alt_a),
    .ex_slot_i     (ex_q),
    .mem_slot_i    (mem_q),
    .sel_o         (sel_a),
    .ex_load_hit_o (a_ld_hit)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_i          (id_rs2),
    .used_i        (id_rs2_used),
    .alt_i         (id_alt_b),
    .ex_slot_i     (ex_q),
    .mem_slot_i    (mem_q),
    .sel_o         (sel_b),
    .ex_load_hit_o (b_ld_hit)
  );

  assign hazard = id_valid & (a_ld_hit | b_ld_hit);

  // The hazard cycle itself is the first stall cycle; STALL covers the
  // remaining LOAD_STALL-1. Once the count is spent, STALL behaves like IDLE
  // against the now-updated slots, so a load-use costs exactly LOAD_STALL.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stall   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hazard) begin
            stall   = 1'b1;
            state_d = STALL;
            hold_d  = HOLD_INIT;
          end
        end
        STALL: begin
          if (hold_q != '0) begin
            stall  = 1'b1;
            hold_d = hold_q - 1'b1;
          end else if (hazard) begin
            stall  = 1'b1;
            hold_d = HOLD_INIT;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = SLOT_RD_W'(id_rd);
      ex_d.wr_en   = id_wr_en;
      ex_d.is_load = id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= IDLE;
      hold_q  <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      // WB is tracked for completeness only; the write-first register file
      // already covers that distance.
      wb_q    <= mem_q;
      state_q <= state_d;
      hold_q  <= hold_d;
      fwd_a_q <= issue ? sel_a : FWD_RF;
      fwd_b_q <= issue ? sel_b : FWD_RF;
      if (stall && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_if_id  = stall;
  assign bubble_ex    = stall;
  assign fwd_a_sel    = fwd_a_q;
  assign fwd_b_sel    = fwd_b_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_rs1_used, id_rs2_used, id_alt_a, id_alt_b;
  logic       id_wr_en, id_is_load, flush;
  logic [3:0] id_rs1, id_rs2, id_rd;

  logic        st[3], bb[3];
  logic [1:0]  fa[3], fb[3];
  logic [15:0] cn0, cn1;
  logic [3:0]  cn2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // u0: LOAD_STALL=1, u1: LOAD_STALL=3, u2: LOAD_STALL=3 with 4-bit counter
  hazard_forward_unit #(.REG_ADDR_W(4), .LOAD_STALL(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_alt_a(id_alt_a),
    .id_alt_b(id_alt_b), .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .flush(flush), .stall_if_id(st[0]), .bubble_ex(bb[0]), .fwd_a_sel(fa[0]),
    .fwd_b_sel(fb[0]), .stall_cycles(cn0));
  hazard_forward_unit #(.REG_ADDR_W(4), .LOAD_STALL(3), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_alt_a(id_alt_a),
    .id_alt_b(id_alt_b), .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .flush(flush), .stall_if_id(st[1]), .bubble_ex(bb[1]), .fwd_a_sel(fa[1]),
    .fwd_b_sel(fb[1]), .stall_cycles(cn1));
  hazard_forward_unit #(.REG_ADDR_W(4), .LOAD_STALL(3), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_alt_a(id_alt_a),
    .id_alt_b(id_alt_b), .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .flush(flush), .stall_if_id(st[2]), .bubble_ex(bb[2]), .fwd_a_sel(fa[2]),
    .fwd_b_sel(fb[2]), .stall_cycles(cn2));

  function automatic int get_cn(int k);
    if (k == 0) return int'(cn0);
    if (k == 1) return int'(cn1);
    return int'(cn2);
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight instructions per stage plus "stall cycles still owed".
  typedef struct packed {logic v; logic [3:0] rd; logic we; logic ld;} ins_t;
  ins_t m_ex[3], m_mem[3], m_wb[3];
  int   m_left[3], m_sa[3], m_sb[3], m_cnt[3];
  int   m_ls[3]  = '{1, 3, 3};
  int   m_max[3] = '{65535, 65535, 15};

  function automatic bit produces(ins_t p, logic [3:0] rs);
    return p.v && p.we && (p.rd == rs);
  endfunction

  function automatic int m_sel(int k, logic [3:0] rs, logic used, logic alt);
    if (alt) return 3;
    if (!used || rs == 0) return 0;
    if (produces(m_ex[k], rs)) return 1;
    if (produces(m_mem[k], rs)) return 2;
    return 0;
  endfunction

  function automatic bit m_hazard(int k);
    bit a, b;
    a = id_rs1_used && !id_alt_a && id_rs1 != 0 && produces(m_ex[k], id_rs1);
    b = id_rs2_used && !id_alt_b && id_rs2 != 0 && produces(m_ex[k], id_rs2);
    return id_valid && m_ex[k].ld && (a || b);
  endfunction

  function automatic bit m_stall(int k);
    if (flush) return 0;
    if (m_left[k] > 0) return 1;
    return m_hazard(k);
  endfunction

  task automatic m_step(int k);
    bit s, iss;
    int sa, sb;
    s   = m_stall(k);
    iss = id_valid && !s && !flush;
    sa  = iss ? m_sel(k, id_rs1, id_rs1_used, id_alt_a) : 0;
    sb  = iss ? m_sel(k, id_rs2, id_rs2_used, id_alt_b) : 0;
    if (flush) m_left[k] = 0;
    else if (m_left[k] > 0) m_left[k]--;
    else if (m_hazard(k)) m_left[k] = m_ls[k] - 1;
    if (s && m_cnt[k] < m_max[k]) m_cnt[k]++;
    m_wb[k]  = m_mem[k];
    m_mem[k] = m_ex[k];
    m_ex[k]  = iss ? ins_t'{1'b1, id_rd, id_wr_en, id_is_load} : ins_t'(0);
    m_sa[k]  = sa;
    m_sb[k]  = sb;
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
      m_left[k] = 0; m_sa[k] = 0; m_sb[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(logic v, logic [3:0] r1, logic [3:0] r2, logic u1, logic u2,
                        logic aa, logic ab, logic [3:0] rd, logic we, logic ld, logic fl);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
    id_alt_a = aa; id_alt_b = ab; id_rd = rd; id_wr_en = we; id_is_load = ld; flush = fl;
  endtask

  task automatic nop();    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic ld_r2();  set_in(1, 1, 0, 1, 0, 0, 0, 2, 1, 1, 0); endtask
  task automatic use_r2(); set_in(1, 2, 2, 1, 1, 0, 0, 4, 1, 0, 0); endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) m_step(k);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nop();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed table (LOAD_STALL=1 instance) ----------------
  typedef struct {
    logic v; logic [3:0] r1, r2; logic u1, u2, aa, ab; logic [3:0] rd; logic we, ld, fl;
    int e_st, e_a, e_b, e_cnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic [3:0] r1, logic [3:0] r2, logic u1, logic u2,
                              logic aa, logic ab, logic [3:0] rd, logic we, logic ld,
                              logic fl, int es, int ea, int eb, int ec);
    vec_t t;
    t.v = v; t.r1 = r1; t.r2 = r2; t.u1 = u1; t.u2 = u2; t.aa = aa; t.ab = ab;
    t.rd = rd; t.we = we; t.ld = ld; t.fl = fl;
    t.e_st = es; t.e_a = ea; t.e_b = eb; t.e_cnt = ec;
    return t;
  endfunction

  vec_t tbl[25];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // expected sel columns belong to the instruction issued in the previous row
    tbl[0]  = mk(1,1,2,1,1,0,0,3,1,0,0, 0,0,0,0); // add r3,r1,r2
    tbl[1]  = mk(1,3,4,1,1,0,0,5,1,0,0, 0,0,0,0); // sub r5,r3,r4
    tbl[2]  = mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0); // sub: A from EX/MEM
    tbl[3]  = mk(1,1,2,1,1,0,0,0,1,0,0, 0,0,0,0); // add r0,r1,r2
    tbl[4]  = mk(1,0,4,1,1,0,0,5,1,0,0, 0,0,0,0); // sub r5,r0,r4
    tbl[5]  = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0); // r0 never forwarded
    tbl[6]  = mk(1,1,2,1,1,0,0,3,1,0,0, 0,0,0,0); // add r3
    tbl[7]  = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0); // nop
    tbl[8]  = mk(1,3,4,1,1,0,0,6,1,0,0, 0,0,0,0); // or r6,r3,r4
    tbl[9]  = mk(0,0,0,0,0,0,0,0,0,0,0, 0,2,0,0); // or: A from MEM/WB
    tbl[10] = mk(1,1,2,1,1,0,0,3,1,0,0, 0,0,0,0); // add r3
    tbl[11] = mk(1,1,2,1,1,0,0,3,1,0,0, 0,0,0,0); // add r3
    tbl[12] = mk(1,3,5,1,1,0,0,7,1,0,0, 0,0,0,0); // and r7,r3,r5
    tbl[13] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0); // newest producer wins
    tbl[14] = mk(1,1,0,1,0,0,0,2,1,1,0, 0,0,0,0); // ld r2,(r1)
    tbl[15] = mk(1,2,2,1,1,0,0,4,1,0,0, 1,0,0,0); // add r4,r2,r2 -> stall
    tbl[16] = mk(1,2,2,1,1,0,0,4,1,0,0, 0,0,0,1); // held add issues
    tbl[17] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,2,2,1); // both from MEM/WB
    tbl[18] = mk(1,2,3,1,1,0,0,1,1,0,0, 0,0,0,1); // add r1,r2,r3
    tbl[19] = mk(1,1,0,1,0,0,1,1,1,0,0, 0,0,0,1); // addi r1,r1,imm
    tbl[20] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,3,1); // A fwd, B alternate
    tbl[21] = mk(1,1,0,1,0,0,0,2,1,1,0, 0,0,0,1); // ld r2,(r1)
    tbl[22] = mk(1,2,2,1,1,0,0,4,1,0,1, 0,2,0,1); // use + flush: no stall
    tbl[23] = mk(1,2,2,1,1,0,0,4,1,0,0, 0,0,0,1); // flushed slot -> 00
    tbl[24] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,2,2,1); // ld now in MEM

    nop();
    #1;
    chk("rst_stall", st[0], 0);
    chk("rst_bubble", bb[0], 0);
    chk("rst_fa", fa[0], 0);
    chk("rst_fb", fb[0], 0);
    chk("rst_cnt", get_cn(0), 0);
    do_reset();

    for (int i = 0; i < 25; i++) begin
      set_in(tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].u1, tbl[i].u2, tbl[i].aa, tbl[i].ab,
             tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d_stall", i), st[0], tbl[i].e_st);
      chk($sformatf("tbl%0d_bubble", i), bb[0], tbl[i].e_st);
      chk($sformatf("tbl%0d_fa", i), fa[0], tbl[i].e_a);
      chk($sformatf("tbl%0d_fb", i), fb[0], tbl[i].e_b);
      chk($sformatf("tbl%0d_cnt", i), get_cn(0), tbl[i].e_cnt);
      tick();
    end

    // LOAD_STALL=3: three stall cycles then release
    do_reset();
    ld_r2(); #1;
    chk("ls3_ld_nostall", st[1], 0);
    tick();
    for (int c = 0; c < 4; c++) begin
      use_r2(); #1;
      chk($sformatf("ls3_stall%0d", c), st[1], (c < 3) ? 1 : 0);
      chk($sformatf("ls3_bubble%0d", c), bb[1], (c < 3) ? 1 : 0);
      tick();
    end
    nop(); #1;
    chk("ls3_fa", fa[1], 0);
    chk("ls3_fb", fb[1], 0);
    chk("ls3_cnt", get_cn(1), 3);
    tick();

    // flush inside the STALL state
    ld_r2(); #1; tick();
    use_r2(); #1;
    chk("fl_stall_start", st[1], 1);
    tick();
    use_r2(); flush = 1'b1; #1;
    chk("fl_stall_drop", st[1], 0);
    chk("fl_bubble_drop", bb[1], 0);
    tick();
    nop(); #1;
    chk("fl_idle", st[1], 0);
    chk("fl_fa", fa[1], 0);
    chk("fl_fb", fb[1], 0);
    chk("fl_cnt", get_cn(1), 4);
    tick();

    // asynchronous reset in the middle of a stall
    ld_r2(); #1; tick();
    use_r2(); #1; tick();
    use_r2(); #1;
    chk("mrst_pre_stall", st[1], 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_stall", st[1], 0);
    chk("mrst_bubble", bb[1], 0);
    chk("mrst_fa", fa[1], 0);
    chk("mrst_fb", fb[1], 0);
    chk("mrst_cnt", get_cn(1), 0);
    do_reset();

    // saturation of a 4-bit counter: 7 load-use pairs = 21 stall cycles
    for (int p = 0; p < 7; p++) begin
      ld_r2(); #1; tick();
      for (int c = 0; c < 4; c++) begin use_r2(); #1; tick(); end
      nop(); #1;
      if (p == 0) chk("sat_first", get_cn(2), 3);
      tick();
    end
    chk("sat_hold", get_cn(2), 15);
    ld_r2(); #1; tick();
    use_r2(); #1;
    chk("sat_still_stalls", st[2], 1);
    tick();

    // randomized run against the reference model
    do_reset();
    begin
      bit hold = 0;
      for (int n = 0; n < 500; n++) begin
        if (!hold)
          set_in($urandom_range(0, 9) != 0, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                 1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 4)), $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, 0);
        flush = ($urandom_range(0, 19) == 0);
        #1;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("rnd%0d_u%0d_stall", n, k), st[k], int'(m_stall(k)));
          chk($sformatf("rnd%0d_u%0d_bubble", n, k), bb[k], int'(m_stall(k)));
          chk($sformatf("rnd%0d_u%0d_fa", n, k), fa[k], m_sa[k]);
          chk($sformatf("rnd%0d_u%0d_fb", n, k), fb[k], m_sb[k]);
          chk($sformatf("rnd%0d_u%0d_cnt", n, k), get_cn(k), m_cnt[k]);
        end
        hold = m_stall(0);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
